// File: rtl/p2s_arb_pkg.sv
// p2s_arb_pkg: shared state encoding and constants for the two-requester parallel2serial arbiter.
package p2s_arb_pkg;
    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BURST
`ifdef P2S_ARB_CHECKSUM_EN
        , CHKSUM
`endif
    } state_t;
endpackage

// File: rtl/p2s_rr_pick.sv
// p2s_rr_pick: two-way round-robin winner selection.
module p2s_rr_pick (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       winner
);
    always_comb winner = (valid == 2'b11) ? ~last_grant : valid[1];
endmodule

// File: rtl/p2s_arbiter.sv
// p2s_arbiter: round-robin burst arbiter feeding a parallel2serial stage with header framing.
// Define P2S_ARB_CHECKSUM_EN to append an XOR checksum byte after each burst.
module p2s_arbiter
    import p2s_arb_pkg::*;
#(
    parameter int         BURST_LEN = 16,
    parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       grant_id,
    output logic       busy,
    output logic       burst_done
);
    state_t           state;
    logic             last_grant;
    logic             winner;
    logic             xfer;
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic [CNT_W-1:0] cnt;
`ifdef P2S_ARB_CHECKSUM_EN
    logic [7:0]       chk;
`endif

    p2s_rr_pick u_pick (
        .valid     ({req1_valid, req0_valid}),
        .last_grant(last_grant),
        .winner    (winner)
    );

    always_comb begin
        sel_valid  = grant_id ? req1_valid : req0_valid;
        sel_data   = grant_id ? req1_data : req0_data;
        busy       = state != IDLE;
        req0_ready = state == BURST && !grant_id && out_ready;
        req1_ready = state == BURST && grant_id && out_ready;
        out_valid  = state == HEADER || (state == BURST && sel_valid);
        out_data   = state == HEADER ? (HDR_BASE | {7'd0, grant_id}) :
                     state == BURST  ? sel_data : 8'd0;
`ifdef P2S_ARB_CHECKSUM_EN
        if (state == CHKSUM) begin
            out_valid = 1'b1;
            out_data  = chk;
        end
`endif
        xfer = out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            burst_done <= 1'b0;
`ifdef P2S_ARB_CHECKSUM_EN
            chk        <= 8'd0;
`endif
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    grant_id <= winner;
                    state    <= HEADER;
                end
                HEADER: if (xfer) begin
                    state <= BURST;
                    cnt   <= '0;
                end
                BURST: if (xfer) begin
                    cnt <= cnt + 1'b1;
`ifdef P2S_ARB_CHECKSUM_EN
                    chk <= chk ^ sel_data;
`endif
                    if (cnt == CNT_W'(BURST_LEN - 1)) begin
                        last_grant <= grant_id;
`ifdef P2S_ARB_CHECKSUM_EN
                        state      <= CHKSUM;
`else
                        state      <= IDLE;
                        burst_done <= 1'b1;
`endif
                    end
                end
`ifdef P2S_ARB_CHECKSUM_EN
                CHKSUM: if (xfer) begin
                    state      <= IDLE;
                    burst_done <= 1'b1;
                    chk        <= 8'd0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/p2s_arbiter.md
P2S_ARBITER -- requirements
Module: p2s_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 16, SHALL set data bytes per granted burst; legal range 2..256.
REQ-002 Parameter HDR_BASE, default 8'hA0, SHALL set the header byte base; bit 0 SHALL be 0.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_valid  input  1  requester 0 byte available.
REQ-007 req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-008 req1_data  input  8  requester 1 byte.
REQ-009 req1_valid  input  1  requester 1 byte available.
REQ-010 req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-011 out_data  output  8  byte to parallel2serial parallel_data.
REQ-012 out_valid  output  1  to parallel2serial parallel_valid.
REQ-013 out_ready  input  1  from parallel2serial parallel_ready_out.
REQ-014 grant_id  output  1  requester owning the current burst.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 burst_done  output  1  one-cycle pulse after the final byte of a burst is accepted.

Function
REQ-017 A transfer SHALL occur on any cycle where valid and ready are both high; no other cycle transfers.
REQ-018 The FSM SHALL have states IDLE, HEADER, BURST, and CHKSUM (CHKSUM only with the macro in REQ-031).
REQ-019 In IDLE with any reqN_valid high, the FSM SHALL register the winner into grant_id and go to HEADER on the next edge; out_valid SHALL be 0 in IDLE.
REQ-020 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; if only one is valid, it wins.
REQ-021 In HEADER, out_data SHALL be HDR_BASE | grant_id and out_valid SHALL be 1, held stable until out_ready; on that transfer the FSM SHALL go to BURST with the byte counter cleared.
REQ-022 In BURST, out_data/out_valid SHALL combinationally equal the granted reqN_data/reqN_valid, and the granted reqN_ready SHALL equal out_ready.
REQ-023 The non-granted reqN_ready SHALL be 0 in all states; both reqN_ready SHALL be 0 outside BURST.
REQ-024 The 8-bit byte counter SHALL increment per BURST transfer; the transfer with count == BURST_LEN-1 SHALL end the burst.
REQ-025 At burst end, burst_done SHALL pulse the following cycle, the last-grant pointer SHALL update, and the FSM SHALL return to IDLE (or CHKSUM per REQ-031).
REQ-026 A granted requester that deasserts valid mid-burst SHALL stall the burst indefinitely; the grant SHALL NOT be revoked and the other requester SHALL NOT be served.
REQ-027 out_ready low in any state SHALL hold state, counter and out_data unchanged.
REQ-028 From the burst-ending cycle, the earliest next header SHALL appear 2 cycles later (via IDLE).

Reset
REQ-029 On reset_n low, state SHALL be IDLE; out_valid, req0_ready, req1_ready, burst_done, busy, grant_id, counter and checksum SHALL be 0; the last-grant pointer SHALL be 1 so requester 0 wins first.
REQ-030 Reset asserted mid-burst SHALL abort without burst_done; after release the aborted requester SHALL restart from a new header.

Configuration
REQ-031 With P2S_ARB_CHECKSUM_EN defined, a registered XOR of the BURST_LEN data bytes (header excluded) SHALL be sent in CHKSUM after the last data byte, with burst_done pulsing after the checksum transfer; without it, CHKSUM and the accumulator SHALL not exist and BURST SHALL go directly to IDLE.

Structure
REQ-032 Package p2s_arb_pkg SHALL hold the state enum, the HDR_BASE default and the counter width constant.
REQ-033 Round-robin selection SHALL live in sub-module p2s_rr_pick (inputs valid[1:0] and last_grant; output winner).

Verification
REQ-034 After reset, both valid, BURST_LEN=4 -> A0, then four req0 bytes, burst_done, then A1 and four req1 bytes.
REQ-035 Only req1 valid, data 11,22,33,44 -> out A1,11,22,33,44; req0_ready stays 0 throughout.
REQ-036 out_ready low for 5 cycles during the header and at byte 2 -> out_data held, no duplicated or lost byte.
REQ-037 Granted req0 drops valid after byte 1 while req1 is valid -> no req1 transfer until req0 finishes the burst.
REQ-038 reset_n pulsed low at byte 2 -> all outputs 0 at once, no burst_done; the next burst starts with A0.
REQ-039 With P2S_ARB_CHECKSUM_EN, bytes 01,02,04,08 -> out A0,01,02,04,08,0F, with burst_done after 0F.
